// File: rtl/nasti_ram_responder.sv
// -----------------------------------------------------------------------------
// nasti_ram_responder
//
// NASTI slave endpoint that terminates one port and backs it with an internal
// word-addressed RAM. One transaction is in flight at a time; reads and writes
// are serialised, and simultaneous requests alternate between the two kinds.
//
// Ports:
//   clk, rstn            clock and asynchronous active-low reset
//   aw_* / aw_valid/ready write address channel (id, addr, len, size, burst, user)
//   w_*  / w_valid/ready  write data channel (data, strb, last, user)
//   b_*  / b_valid/ready  write response channel (id, resp, user)
//   ar_* / ar_valid/ready read address channel (same fields as aw_*)
//   r_*  / r_valid/ready  read data channel (id, data, resp, last, user)
// -----------------------------------------------------------------------------
module nasti_ram_responder #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [2:0]              aw_size,
    input  logic [1:0]              aw_burst,
    input  logic [USER_WIDTH-1:0]   aw_user,
    input  logic                    aw_valid,
    output logic                    aw_ready,

    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    input  logic [USER_WIDTH-1:0]   w_user,
    input  logic                    w_valid,
    output logic                    w_ready,

    output logic [ID_WIDTH-1:0]     b_id,
    output logic [1:0]              b_resp,
    output logic [USER_WIDTH-1:0]   b_user,
    output logic                    b_valid,
    input  logic                    b_ready,

    input  logic [ID_WIDTH-1:0]     ar_id,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]              ar_len,
    input  logic [2:0]              ar_size,
    input  logic [1:0]              ar_burst,
    input  logic [USER_WIDTH-1:0]   ar_user,
    input  logic                    ar_valid,
    output logic                    ar_ready,

    output logic [ID_WIDTH-1:0]     r_id,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp,
    output logic                    r_last,
    output logic [USER_WIDTH-1:0]   r_user,
    output logic                    r_valid,
    input  logic                    r_ready
);

    localparam int OFFSET = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W  = ADDR_WIDTH - OFFSET;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [2:0] FULL_SIZE   = 3'(OFFSET);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WRESP,
        RADDR,
        RDATA
    } state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     id_q;
    logic [USER_WIDTH-1:0]   user_q;
    logic [7:0]              len_q;
    logic [7:0]              beat;
    logic [IDX_W-1:0]        idx;
    logic                    fixed_q;
    logic                    txn_err;
    logic                    acc_err;
    logic                    prefer_write;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   rd_q;

    logic                    in_range;
    logic                    is_last;
    logic [IDX_W-1:0]        next_idx;
    logic [MEM_AW-1:0]       mem_addr;
    logic                    w_beat_err;
    logic                    wr_en;
    logic                    unused_bits;

    // Current beat bookkeeping: the word index is the byte address with the
    // lane bits dropped, so it wraps naturally at the top of the address space.
    // Beats beyond the physical RAM are flagged rather than aliased.
    assign in_range   = (32'(idx) < 32'(MEM_DEPTH));
    assign is_last    = (beat == len_q);
    assign next_idx   = fixed_q ? idx : idx + IDX_W'(1);
    assign mem_addr   = MEM_AW'(idx);
    assign w_beat_err = !in_range || (w_last != is_last);
    assign wr_en      = (state == WDATA) && w_valid && w_ready && !txn_err && in_range;

    // Read data comes straight from the RAM output register; it only changes
    // while in RADDR, which keeps it stable across an r_ready stall.
    assign r_data = rd_q;

    // Low address lane bits and w_user carry no meaning for this responder.
    assign unused_bits = ^{w_user, aw_addr, ar_addr};

    // Main control FSM. In IDLE the chosen ready is raised for exactly one
    // cycle; the request fields are latched in that same cycle because the
    // master must hold them stable while valid is high. Write beats end after
    // len+1 handshakes irrespective of w_last, and any error seen along the way
    // is folded into the single B response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            aw_ready     <= 1'b0;
            ar_ready     <= 1'b0;
            w_ready      <= 1'b0;
            b_valid      <= 1'b0;
            b_id         <= '0;
            b_resp       <= RESP_OKAY;
            b_user       <= '0;
            r_valid      <= 1'b0;
            r_id         <= '0;
            r_resp       <= RESP_OKAY;
            r_last       <= 1'b0;
            r_user       <= '0;
            prefer_write <= 1'b1;
            id_q         <= '0;
            user_q       <= '0;
            len_q        <= '0;
            beat         <= '0;
            idx          <= '0;
            fixed_q      <= 1'b0;
            txn_err      <= 1'b0;
            acc_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_ready) begin
                        aw_ready     <= 1'b0;
                        id_q         <= aw_id;
                        user_q       <= aw_user;
                        len_q        <= aw_len;
                        idx          <= aw_addr[ADDR_WIDTH-1:OFFSET];
                        fixed_q      <= (aw_burst == BURST_FIXED);
                        txn_err      <= aw_burst[1] || (aw_size != FULL_SIZE);
                        acc_err      <= 1'b0;
                        beat         <= '0;
                        prefer_write <= 1'b0;
                        w_ready      <= 1'b1;
                        state        <= WDATA;
                    end else if (ar_ready) begin
                        ar_ready     <= 1'b0;
                        id_q         <= ar_id;
                        user_q       <= ar_user;
                        len_q        <= ar_len;
                        idx          <= ar_addr[ADDR_WIDTH-1:OFFSET];
                        fixed_q      <= (ar_burst == BURST_FIXED);
                        txn_err      <= ar_burst[1] || (ar_size != FULL_SIZE);
                        acc_err      <= 1'b0;
                        beat         <= '0;
                        prefer_write <= 1'b1;
                        state        <= RADDR;
                    end else if (aw_valid && (!ar_valid || prefer_write)) begin
                        aw_ready <= 1'b1;
                    end else if (ar_valid) begin
                        ar_ready <= 1'b1;
                    end
                end

                WDATA: begin
                    if (w_valid && w_ready) begin
                        if (is_last) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            b_id    <= id_q;
                            b_user  <= user_q;
                            b_resp  <= (txn_err || acc_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state   <= WRESP;
                        end else begin
                            acc_err <= acc_err || w_beat_err;
                            beat    <= beat + 8'd1;
                            idx     <= next_idx;
                        end
                    end
                end

                WRESP: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end

                RADDR: begin
                    r_valid <= 1'b1;
                    r_id    <= id_q;
                    r_user  <= user_q;
                    r_resp  <= (txn_err || !in_range) ? RESP_SLVERR : RESP_OKAY;
                    r_last  <= is_last;
                    state   <= RDATA;
                end

                RDATA: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            state <= IDLE;
                        end else begin
                            beat  <= beat + 8'd1;
                            idx   <= next_idx;
                            state <= RADDR;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane RAM write. The array has no reset so it can map onto block RAM;
    // errored transactions and out-of-range beats never reach here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (w_strb[b]) begin
                    mem[mem_addr][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    // Synchronous RAM read, performed once per read beat in RADDR. Errored
    // beats load zero so the master never sees stale contents on SLVERR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= '0;
        end else if (state == RADDR) begin
            rd_q <= (!txn_err && in_range) ? mem[mem_addr] : '0;
        end
    end

endmodule

// File: tb/tb_nasti_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_nasti_ram_responder
//
// Directed self-checking bench for nasti_ram_responder. Drivers act on the
// falling clock edge; each test_* task drives its scenario and compares the
// observed channel values against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_nasti_ram_responder;

    localparam int ID_WIDTH   = 1;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 64;
    localparam int USER_WIDTH = 1;
    localparam int MEM_DEPTH  = 1024;
    localparam int BUDGET     = 100;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b1;

    logic [ID_WIDTH-1:0]     aw_id = '0;
    logic [ADDR_WIDTH-1:0]   aw_addr = '0;
    logic [7:0]              aw_len = '0;
    logic [2:0]              aw_size = '0;
    logic [1:0]              aw_burst = '0;
    logic [USER_WIDTH-1:0]   aw_user = '0;
    logic                    aw_valid = 1'b0;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data = '0;
    logic [DATA_WIDTH/8-1:0] w_strb = '0;
    logic                    w_last = 1'b0;
    logic [USER_WIDTH-1:0]   w_user = '0;
    logic                    w_valid = 1'b0;
    logic                    w_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready = 1'b0;
    logic [ID_WIDTH-1:0]     ar_id = '0;
    logic [ADDR_WIDTH-1:0]   ar_addr = '0;
    logic [7:0]              ar_len = '0;
    logic [2:0]              ar_size = '0;
    logic [1:0]              ar_burst = '0;
    logic [USER_WIDTH-1:0]   ar_user = '0;
    logic                    ar_valid = 1'b0;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] wbeat     [16];
    logic [7:0]  wstrb_arr [16];
    logic        wlast_arr [16];
    logic [63:0] rbeat     [16];
    logic [1:0]  rresp_arr [16];
    logic        rlast_arr [16];
    logic [ID_WIDTH-1:0]   rid_seen;
    logic [USER_WIDTH-1:0] ruser_seen;
    int          unstable;
    logic [1:0]  bresp_seen;
    logic [ID_WIDTH-1:0]   bid_seen;
    logic [USER_WIDTH-1:0] buser_seen;
    bit          b_dropped;

    always #5 clk = ~clk;

    nasti_ram_responder #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .aw_id    (aw_id),
        .aw_addr  (aw_addr),
        .aw_len   (aw_len),
        .aw_size  (aw_size),
        .aw_burst (aw_burst),
        .aw_user  (aw_user),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .w_last   (w_last),
        .w_user   (w_user),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .b_id     (b_id),
        .b_resp   (b_resp),
        .b_user   (b_user),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .ar_id    (ar_id),
        .ar_addr  (ar_addr),
        .ar_len   (ar_len),
        .ar_size  (ar_size),
        .ar_burst (ar_burst),
        .ar_user  (ar_user),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .r_id     (r_id),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .r_last   (r_last),
        .r_user   (r_user),
        .r_valid  (r_valid),
        .r_ready  (r_ready)
    );

    // ---------------------------------------------------------------- drivers
    task automatic timeout_fail(input string what);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL timeout_%s: no handshake within %0d cycles, required one", what, BUDGET);
    endtask

    task automatic fill_w(input int len, input logic [63:0] base);
        for (int i = 0; i <= len; i++) begin
            wbeat[i]     = base + 64'(i);
            wstrb_arr[i] = 8'hFF;
            wlast_arr[i] = (i == len);
        end
    endtask

    task automatic drive_aw(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                            input logic [USER_WIDTH-1:0] user);
        aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_size = size; aw_user = user;
        aw_valid = 1'b1;
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!aw_ready && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) timeout_fail("aw");
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic drive_ar(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                            input logic [USER_WIDTH-1:0] user);
        ar_id = id; ar_addr = addr; ar_len = len; ar_burst = burst; ar_size = size; ar_user = user;
        ar_valid = 1'b1;
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!ar_ready && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) timeout_fail("ar");
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic send_w(input int len);
        for (int i = 0; i <= len; i++) begin
            int n = 0;
            w_data = wbeat[i]; w_strb = wstrb_arr[i]; w_last = wlast_arr[i];
            w_valid = 1'b1;
            while (!w_ready && n < BUDGET) begin @(negedge clk); n++; end
            if (n >= BUDGET) timeout_fail("w");
            @(negedge clk);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic get_b(input int stall);
        int n = 0;
        b_dropped = 1'b0;
        while (!b_valid && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) timeout_fail("b");
        for (int k = 0; k < stall; k++) begin
            if (!b_valid) b_dropped = 1'b1;
            @(negedge clk);
        end
        if (!b_valid) b_dropped = 1'b1;
        bresp_seen = b_resp; bid_seen = b_id; buser_seen = b_user;
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic get_r(input int len, input logic [3:0] pat);
        int nb = 0;
        int c  = 0;
        bit prev_stall = 1'b0;
        logic [63:0] held_data = '0;
        logic [1:0]  held_resp = '0;
        logic        held_last = 1'b0;
        unstable = 0;
        for (int i = 0; i < 16; i++) begin
            rbeat[i] = 64'hBAD0BAD0BAD0BAD0; rresp_arr[i] = 2'b11; rlast_arr[i] = 1'bx;
        end
        while (nb <= len && c < 4 * BUDGET) begin
            r_ready = pat[c % 4];
            if (prev_stall && (r_valid !== 1'b1 || r_data !== held_data ||
                               r_last !== held_last || r_resp !== held_resp))
                unstable++;
            if (r_valid && r_ready) begin
                rbeat[nb] = r_data; rresp_arr[nb] = r_resp; rlast_arr[nb] = r_last;
                rid_seen = r_id; ruser_seen = r_user;
                nb++;
            end
            prev_stall = r_valid && !r_ready;
            held_data = r_data; held_resp = r_resp; held_last = r_last;
            @(negedge clk);
            c++;
        end
        r_ready = 1'b0;
        if (nb <= len) timeout_fail("r");
    endtask

    task automatic do_write(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                            input int len, input logic [1:0] burst, input logic [2:0] size,
                            input logic [USER_WIDTH-1:0] user, input int stall);
        drive_aw(id, addr, 8'(len), burst, size, user);
        wait_aw();
        send_w(len);
        get_b(stall);
    endtask

    task automatic do_read(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                           input int len, input logic [1:0] burst, input logic [2:0] size,
                           input logic [USER_WIDTH-1:0] user, input logic [3:0] pat);
        drive_ar(id, addr, 8'(len), burst, size, user);
        wait_ar();
        get_r(len, pat);
    endtask

    task automatic pulse_reset();
        aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshakes: got %b, expected 00000",
                     {aw_ready, ar_ready, w_ready, b_valid, r_valid});
        end
        tests_run++;
        if ({b_resp, b_id, r_data, r_resp, r_last} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_payload: got b_resp=%0h r_data=%0h r_last=%0b, expected all 0",
                     b_resp, r_data, r_last);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        fill_w(3, 64'd1);
        do_write(1'b1, 16'h0040, 3, INCR, 3'd3, 1'b1, 0);
        tests_run++;
        if ({bresp_seen, bid_seen, buser_seen} !== {OKAY, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL wr_bresp: got resp=%0h id=%0h user=%0h, expected 0/1/1",
                     bresp_seen, bid_seen, buser_seen);
        end
        do_read(1'b1, 16'h0040, 3, INCR, 3'd3, 1'b1, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rbeat[i] !== 64'(i + 1) || rresp_arr[i] !== OKAY || rlast_arr[i] !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL rd_beat%0d: got data=%0h resp=%0h last=%0b, expected %0h/0/%0b",
                         i, rbeat[i], rresp_arr[i], rlast_arr[i], i + 1, i == 3);
            end
        end
        tests_run++;
        if ({rid_seen, ruser_seen} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL rd_id_user: got %0h/%0h, expected 1/1", rid_seen, ruser_seen);
        end
    endtask

    task automatic test_latency();
        drive_ar(1'b0, 16'h0040, 8'd0, INCR, 3'd3, 1'b0);
        wait_ar();
        tests_run++;
        if (r_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ar_lat_early: got r_valid=%b, expected 0", r_valid);
        end
        @(negedge clk);
        tests_run++;
        if (r_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ar_lat: got r_valid=%b, expected 1", r_valid);
        end
        get_r(0, 4'b1111);
        tests_run++;
        if (rbeat[0] !== 64'd1) begin
            tests_failed++;
            $display("[TB] FAIL lat_data: got %0h, expected 1", rbeat[0]);
        end
        drive_aw(1'b0, 16'h0048, 8'd0, INCR, 3'd3, 1'b0);
        wait_aw();
        tests_run++;
        if (w_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL aw_lat: got w_ready=%b, expected 1", w_ready);
        end
        fill_w(0, 64'd2);
        send_w(0);
        tests_run++;
        if (b_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b_lat: got b_valid=%b, expected 1", b_valid);
        end
        get_b(0);
    endtask

    task automatic test_strobes();
        fill_w(0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_write(1'b0, 16'h0080, 0, INCR, 3'd3, 1'b0, 0);
        wbeat[0] = 64'h1122_3344_5566_7788;
        wstrb_arr[0] = 8'h0F;
        do_write(1'b0, 16'h0080, 0, INCR, 3'd3, 1'b0, 0);
        do_read(1'b0, 16'h0080, 0, INCR, 3'd3, 1'b0, 4'b1111);
        tests_run++;
        if (rbeat[0] !== 64'hFFFF_FFFF_5566_7788) begin
            tests_failed++;
            $display("[TB] FAIL strobe: got %0h, expected ffffffff55667788", rbeat[0]);
        end
    endtask

    task automatic test_fixed_burst();
        fill_w(1, 64'h0);
        wbeat[0] = 64'h11;
        wbeat[1] = 64'h22;
        do_write(1'b0, 16'h0400, 1, FIXED, 3'd3, 1'b0, 0);
        do_read(1'b0, 16'h0400, 0, INCR, 3'd3, 1'b0, 4'b1111);
        tests_run++;
        if (rbeat[0] !== 64'h22 || bresp_seen !== OKAY) begin
            tests_failed++;
            $display("[TB] FAIL fixed_burst: got data=%0h bresp=%0h, expected 22/0", rbeat[0], bresp_seen);
        end
    endtask

    task automatic test_arbitration();
        int n = 0;
        pulse_reset();
        drive_aw(1'b0, 16'h0100, 8'd0, INCR, 3'd3, 1'b0);
        drive_ar(1'b1, 16'h0040, 8'd0, INCR, 3'd3, 1'b1);
        while (!(aw_ready || ar_ready) && n < BUDGET) begin @(negedge clk); n++; end
        tests_run++;
        if ({aw_ready, ar_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL tie1_winner: got aw/ar ready=%b, expected 10", {aw_ready, ar_ready});
        end
        wait_aw();
        fill_w(0, 64'hA5);
        send_w(0);
        n = 0;
        while (!b_valid && n < BUDGET) begin @(negedge clk); n++; end
        if (n >= BUDGET) timeout_fail("tie_b");
        b_ready = 1'b1;
        drive_aw(1'b0, 16'h0108, 8'd0, INCR, 3'd3, 1'b0);
        @(negedge clk);
        b_ready = 1'b0;
        n = 0;
        while (!(aw_ready || ar_ready) && n < BUDGET) begin @(negedge clk); n++; end
        tests_run++;
        if ({aw_ready, ar_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL tie2_winner: got aw/ar ready=%b, expected 01", {aw_ready, ar_ready});
        end
        wait_ar();
        get_r(0, 4'b1111);
        tests_run++;
        if (rbeat[0] !== 64'd1 || rid_seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL tie_read: got data=%0h id=%0h, expected 1/1", rbeat[0], rid_seen);
        end
        wait_aw();
        fill_w(0, 64'h5A);
        send_w(0);
        get_b(0);
        tests_run++;
        if (bresp_seen !== OKAY) begin
            tests_failed++;
            $display("[TB] FAIL tie_write: got bresp=%0h, expected 0", bresp_seen);
        end
    endtask

    task automatic test_back_to_back();
        fill_w(7, 64'h1000);
        do_write(1'b1, 16'h0200, 7, INCR, 3'd3, 1'b0, 5);
        tests_run++;
        if (b_dropped !== 1'b0 || bresp_seen !== OKAY) begin
            tests_failed++;
            $display("[TB] FAIL b_stall: got dropped=%b resp=%0h, expected 0/0", b_dropped, bresp_seen);
        end
        do_read(1'b1, 16'h0200, 7, INCR, 3'd3, 1'b0, 4'b1001);
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (rbeat[i] !== 64'h1000 + 64'(i) || rlast_arr[i] !== (i == 7) || rresp_arr[i] !== OKAY) begin
                tests_failed++;
                $display("[TB] FAIL bp_beat%0d: got data=%0h last=%0b resp=%0h, expected %0h/%0b/0",
                         i, rbeat[i], rlast_arr[i], rresp_arr[i], 64'h1000 + 64'(i), i == 7);
            end
        end
        tests_run++;
        if (unstable !== 0) begin
            tests_failed++;
            $display("[TB] FAIL r_stable: got %0d changes during stall, expected 0", unstable);
        end
    endtask

    task automatic test_errors();
        fill_w(3, 64'hDEAD_0000);
        do_write(1'b0, 16'h0040, 3, WRAP, 3'd3, 1'b0, 0);
        tests_run++;
        if (bresp_seen !== SLVERR) begin
            tests_failed++;
            $display("[TB] FAIL wrap_bresp: got %0h, expected 2", bresp_seen);
        end
        fill_w(0, 64'hBEEF);
        do_write(1'b0, 16'h0040, 0, INCR, 3'd2, 1'b0, 0);
        tests_run++;
        if (bresp_seen !== SLVERR) begin
            tests_failed++;
            $display("[TB] FAIL size_bresp: got %0h, expected 2", bresp_seen);
        end
        do_read(1'b0, 16'h0040, 3, INCR, 3'd3, 1'b0, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rbeat[i] !== 64'(i + 1) || rresp_arr[i] !== OKAY) begin
                tests_failed++;
                $display("[TB] FAIL ram_unchanged%0d: got %0h/%0h, expected %0h/0",
                         i, rbeat[i], rresp_arr[i], i + 1);
            end
        end
        do_read(1'b0, 16'h0040, 1, WRAP, 3'd3, 1'b0, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (rbeat[i] !== 64'd0 || rresp_arr[i] !== SLVERR || rlast_arr[i] !== (i == 1)) begin
                tests_failed++;
                $display("[TB] FAIL wrap_read%0d: got %0h/%0h/%0b, expected 0/2/%0b",
                         i, rbeat[i], rresp_arr[i], rlast_arr[i], i == 1);
            end
        end
        fill_w(1, 64'h0);
        wbeat[0] = 64'hCAFE;
        wbeat[1] = 64'hBEEF;
        do_write(1'b0, 16'h1FF8, 1, INCR, 3'd3, 1'b0, 0);
        tests_run++;
        if (bresp_seen !== SLVERR) begin
            tests_failed++;
            $display("[TB] FAIL edge_bresp: got %0h, expected 2", bresp_seen);
        end
        do_read(1'b0, 16'h1FF8, 1, INCR, 3'd3, 1'b0, 4'b1111);
        tests_run++;
        if (rbeat[0] !== 64'hCAFE || rresp_arr[0] !== OKAY) begin
            tests_failed++;
            $display("[TB] FAIL edge_beat0: got %0h/%0h, expected cafe/0", rbeat[0], rresp_arr[0]);
        end
        tests_run++;
        if (rbeat[1] !== 64'd0 || rresp_arr[1] !== SLVERR || rlast_arr[1] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL edge_beat1: got %0h/%0h/%0b, expected 0/2/1", rbeat[1], rresp_arr[1], rlast_arr[1]);
        end
        fill_w(1, 64'h77);
        wlast_arr[0] = 1'b1;
        do_write(1'b0, 16'h0300, 1, INCR, 3'd3, 1'b0, 0);
        tests_run++;
        if (bresp_seen !== SLVERR) begin
            tests_failed++;
            $display("[TB] FAIL early_wlast: got %0h, expected 2", bresp_seen);
        end
        fill_w(0, 64'h88);
        wlast_arr[0] = 1'b0;
        do_write(1'b0, 16'h0308, 0, INCR, 3'd3, 1'b0, 0);
        tests_run++;
        if (bresp_seen !== SLVERR) begin
            tests_failed++;
            $display("[TB] FAIL missing_wlast: got %0h, expected 2", bresp_seen);
        end
    endtask

    task automatic test_reset_midburst();
        int nb = 0;
        int c  = 0;
        drive_ar(1'b0, 16'h0040, 8'd3, INCR, 3'd3, 1'b0);
        wait_ar();
        r_ready = 1'b1;
        while (c < BUDGET) begin
            if (r_valid) begin
                if (nb == 2) break;
                nb++;
            end
            @(negedge clk);
            c++;
        end
        if (c >= BUDGET) timeout_fail("midburst");
        tests_run++;
        if (r_data !== 64'd3) begin
            tests_failed++;
            $display("[TB] FAIL midburst_beat2: got %0h, expected 3", r_data);
        end
        r_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL midburst_abort: got %b, expected 00000",
                     {aw_ready, ar_ready, w_ready, b_valid, r_valid});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_read(1'b0, 16'h0040, 3, INCR, 3'd3, 1'b0, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rbeat[i] !== 64'(i + 1) || rlast_arr[i] !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL post_reset%0d: got %0h/%0b, expected %0h/%0b",
                         i, rbeat[i], rlast_arr[i], i + 1, i == 3);
            end
        end
    endtask

    // Runs every scenario in order, then prints the single summary line.
    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_strobes();
        test_fixed_burst();
        test_arbitration();
        test_back_to_back();
        test_errors();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Backstop against a wedged run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
